// File: rtl/dmem_wait.sv
// dmem_wait: single-port data memory with a fixed response latency.
//
// A request is captured while the FSM is idle or in its response cycle. The
// FSM then waits WAIT_CYCLES cycles and raises ready for exactly one cycle.
// Reads load rd on the edge that enters the response cycle. Writes are
// byte-masked and committed on the edge that leaves the response cycle.
// Misaligned or out-of-range accesses report err with ready, write nothing
// and return rd = 0. Memory contents are not touched by reset.
//
// Ports:
//   clk    - clock, all state changes on the rising edge
//   reset  - asynchronous active-low reset
//   req    - access request (sampled only in idle or in the response cycle)
//   we     - 1 = write, 0 = read (captured with req)
//   a      - byte address (captured with req)
//   wd     - write data (captured with req)
//   be     - write byte enables (captured with req)
//   rd     - registered read data
//   ready  - one-cycle response pulse
//   err    - error flag, meaningful only while ready = 1
//   stall  - req & ~ready, freezes the pipeline memory stage
module dmem_wait #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req,
  input  logic                we,
  input  logic [ADDR_W-1:0]   a,
  input  logic [DATA_W-1:0]   wd,
  input  logic [DATA_W/8-1:0] be,
  output logic [DATA_W-1:0]   rd,
  output logic                ready,
  output logic                err,
  output logic                stall
);

  localparam int unsigned BeW   = DATA_W / 8;
  localparam int unsigned IdxW  = ADDR_W - 2;
  localparam int unsigned MemAw = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Word-index bound; assumes DEPTH is representable in ADDR_W-2 bits.
  localparam logic [IdxW-1:0] DepthIdx = IdxW'(DEPTH);
  localparam logic [3:0]      WaitInit = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t            r_state;
  logic [3:0]        r_cnt;
  logic              r_we;
  logic [ADDR_W-1:0] r_a;
  logic [DATA_W-1:0] r_wd;
  logic [BeW-1:0]    r_be;
  logic [DATA_W-1:0] r_rd;
  logic              r_ready;
  logic              r_err;

  logic [DATA_W-1:0] r_mem [DEPTH];

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic              w_cap;
  logic              w_enter_resp;
  logic              w_acc_we;
  logic [ADDR_W-1:0] w_acc_a;
  logic [IdxW-1:0]   w_acc_idx;
  logic              w_acc_err;
  logic              w_wr_en;
  logic [MemAw-1:0]  w_wr_idx;
  logic [DATA_W-1:0] w_rdata;

  // A request is accepted only while idle or in the response cycle.
  assign w_cap = req & ((r_state == StIdle) | (r_state == StResp));

  // Entering the response cycle: either directly on capture (no wait states)
  // or after the last wait cycle.
  assign w_enter_resp = (w_cap & (WAIT_CYCLES == 0)) |
                        ((r_state == StWait) & (r_cnt == 4'd1));

  // With no wait states the response is produced on the capture edge, so the
  // access fields come straight from the ports; otherwise from the capture regs.
  assign w_acc_we  = w_cap ? we : r_we;
  assign w_acc_a   = w_cap ? a  : r_a;
  assign w_acc_idx = w_acc_a[ADDR_W-1:2];
  assign w_acc_err = (w_acc_a[1:0] != 2'b00) | (w_acc_idx >= DepthIdx);

  // The pending write commits on the edge leaving the response cycle.
  assign w_wr_en  = (r_state == StResp) & r_we & ~r_err;
  assign w_wr_idx = r_a[MemAw+1:2];

  // Read data with bypass of the write committing on this same edge; only
  // reachable with zero wait states and a back-to-back read of that word.
  always_comb begin
    w_rdata = r_mem[w_acc_idx[MemAw-1:0]];
    if (w_wr_en && (r_a[ADDR_W-1:2] == w_acc_idx)) begin
      for (int unsigned b = 0; b < BeW; b++) begin
        if (r_be[b]) begin
          w_rdata[8*b +: 8] = r_wd[8*b +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StIdle;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_a     <= '0;
      r_wd    <= '0;
      r_be    <= '0;
      r_rd    <= '0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_ready <= w_enter_resp;
      r_err   <= w_enter_resp & w_acc_err;

      if (w_enter_resp) begin
        if (w_acc_err) begin
          r_rd <= '0;
        end else if (!w_acc_we) begin
          r_rd <= w_rdata;
        end
      end

      if (w_cap) begin
        r_we  <= we;
        r_a   <= a;
        r_wd  <= wd;
        r_be  <= be;
        if (WAIT_CYCLES == 0) begin
          r_cnt   <= 4'd0;
          r_state <= StResp;
        end else begin
          r_cnt   <= WaitInit;
          r_state <= StWait;
        end
      end else if (r_state == StWait) begin
        r_cnt <= r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          r_state <= StResp;
        end
      end else begin
        // Response cycle without a new request, idle, or an unused encoding.
        r_state <= StIdle;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Storage (no reset: contents survive reset)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int unsigned b = 0; b < BeW; b++) begin
        if (r_be[b]) begin
          r_mem[w_wr_idx][8*b +: 8] <= r_wd[8*b +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign rd    = r_rd;
  assign ready = r_ready;
  assign err   = r_err;
  assign stall = req & ~r_ready;

endmodule

// File: tb/tb_dmem_wait.sv
// Bench for dmem_wait: one instance with WAIT_CYCLES=2 and one with
// WAIT_CYCLES=0, checked against a word-array model of the memory.
module tb_dmem_wait;

  localparam int unsigned Depth = 64;
  localparam int unsigned WaitC = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // Instance with wait states
  logic        req, we;
  logic [31:0] a, wd, rd;
  logic [3:0]  be;
  logic        ready, err, stall;

  // Instance without wait states
  logic        req0, we0;
  logic [31:0] a0, wd0, rd0;
  logic [3:0]  be0;
  logic        ready0, err0, stall0;

  dmem_wait #(.DATA_W(32), .ADDR_W(32), .DEPTH(Depth), .WAIT_CYCLES(WaitC)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .a(a), .wd(wd), .be(be),
    .rd(rd), .ready(ready), .err(err), .stall(stall)
  );

  dmem_wait #(.DATA_W(32), .ADDR_W(32), .DEPTH(Depth), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .req(req0), .we(we0), .a(a0), .wd(wd0), .be(be0),
    .rd(rd0), .ready(ready0), .err(err0), .stall(stall0)
  );

  int checks = 0;
  int errors = 0;

  // Reference state
  logic [31:0] mem2 [Depth];
  logic [31:0] mem0 [Depth];
  logic [31:0] exp_rd2, exp_rd0;

  // Access captured by the wait-state instance
  logic        c_we;
  logic [31:0] c_a, c_wd;
  logic [3:0]  c_be;

  // Current op of the zero-wait instance
  logic        o_we;
  logic [31:0] o_a, o_wd;
  logic [3:0]  o_be;

  logic [31:0] old14;

  function automatic logic addr_err(input logic [31:0] addr);
    return (addr[1:0] != 2'b00) || ((addr >> 2) >= Depth);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                         input logic [3:0] en);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (en[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

  function automatic logic [31:0] rand_addr(input int unsigned words);
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r < 7) return 32'($urandom_range(0, words - 1) * 4);
    if (r == 7) return 32'($urandom_range(0, words - 1) * 4 + $urandom_range(1, 3));
    return 32'((Depth + $urandom_range(0, 100)) * 4);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive a request at a negedge and let the next rising edge capture it.
  task automatic start2(input logic w, input logic [31:0] ad, input logic [31:0] d,
                        input logic [3:0] e);
    c_we = w; c_a = ad; c_wd = d; c_be = e;
    req = 1'b1; we = w; a = ad; wd = d; be = e;
    @(posedge clk);
  endtask

  // Wait for the response, scrambling the inputs meanwhile; returns at the
  // negedge inside the response cycle with req still high.
  task automatic finish2();
    int  n;
    bit  seen;
    logic e;
    n = 0;
    seen = 0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (ready === 1'b1) begin
        seen = 1;
      end else begin
        chk("stall_wait", {31'b0, stall}, 32'd1);
        we = 1'($urandom);
        a  = $urandom;
        wd = $urandom;
        be = 4'($urandom);
      end
    end
    chk("latency", 32'(n), 32'(WaitC + 1));
    chk("stall_resp", {31'b0, stall}, 32'd0);
    e = addr_err(c_a);
    chk("err", {31'b0, err}, {31'b0, e});
    if (e) exp_rd2 = 32'd0;
    else if (!c_we) exp_rd2 = mem2[int'(c_a >> 2)];
    chk("rd", rd, exp_rd2);
    if (!e && c_we) mem2[int'(c_a >> 2)] = merge(mem2[int'(c_a >> 2)], c_wd, c_be);
  endtask

  task automatic access2(input logic w, input logic [31:0] ad, input logic [31:0] d,
                         input logic [3:0] e);
    start2(w, ad, d, e);
    finish2();
    req = 1'b0;
    @(negedge clk);
    chk("ready_idle", {31'b0, ready}, 32'd0);
  endtask

  task automatic gen0(input int k);
    if (k < 8) begin
      o_we = 1'b1; o_a = 32'(k * 4); o_wd = $urandom; o_be = 4'hF;
    end else begin
      o_we = 1'($urandom);
      o_a  = rand_addr(8);
      o_wd = $urandom;
      o_be = 4'($urandom);
    end
    req0 = 1'b1; we0 = o_we; a0 = o_a; wd0 = o_wd; be0 = o_be;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    req = 1'b0; we = 1'b0; a = '0; wd = '0; be = '0;
    req0 = 1'b0; we0 = 1'b0; a0 = '0; wd0 = '0; be0 = '0;
    exp_rd2 = '0;
    exp_rd0 = '0;
    #1;
    chk("reset_rd", rd, 32'd0);
    chk("reset_ready", {31'b0, ready}, 32'd0);
    chk("reset_err", {31'b0, err}, 32'd0);
    chk("reset_rd0", rd0, 32'd0);
    chk("reset_ready0", {31'b0, ready0}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Fill every word so later reads have a defined expectation.
    for (int i = 0; i < int'(Depth); i++) access2(1'b1, 32'(i * 4), $urandom, 4'hF);

    // Full write then read back.
    access2(1'b1, 32'h8, 32'hDEADBEEF, 4'hF);
    access2(1'b0, 32'h8, 32'h0, 4'h0);
    chk("rd_deadbeef", rd, 32'hDEADBEEF);

    // Byte-masked write over it.
    access2(1'b1, 32'h8, 32'h11223344, 4'b0101);
    access2(1'b0, 32'h8, 32'h0, 4'h0);
    chk("rd_merge", rd, 32'hDE22BE44);

    // Misaligned and out-of-range accesses, including a write that must not land.
    access2(1'b0, 32'h6, 32'h0, 4'h0);
    access2(1'b0, 32'(Depth * 4), 32'h0, 4'h0);
    access2(1'b1, 32'h9, 32'hFFFFFFFF, 4'hF);
    access2(1'b0, 32'h8, 32'h0, 4'h0);
    chk("rd_unchanged", rd, 32'hDE22BE44);

    // be = 0 write completes and changes nothing.
    access2(1'b1, 32'h8, 32'h55555555, 4'h0);
    access2(1'b0, 32'h8, 32'h0, 4'h0);
    chk("rd_be0", rd, 32'hDE22BE44);

    // Back-to-back write then read with req held high.
    start2(1'b1, 32'h10, 32'hCAFEF00D, 4'hF);
    finish2();
    start2(1'b0, 32'h10, 32'h0, 4'h0);
    finish2();
    chk("rd_b2b", rd, 32'hCAFEF00D);
    req = 1'b0;
    @(negedge clk);

    // Random traffic, some of it chained back-to-back.
    for (int i = 0; i < 40; i++) begin
      start2(1'($urandom), rand_addr(Depth), $urandom, 4'($urandom));
      finish2();
      if ($urandom_range(0, 2) == 0) begin
        start2(1'($urandom), rand_addr(Depth), $urandom, 4'($urandom));
        finish2();
      end
      req = 1'b0;
      @(negedge clk);
    end

    // Zero-wait instance: continuous requests, one response per cycle.
    gen0(0);
    for (int k = 0; k < 48; k++) begin
      logic e0;
      @(posedge clk);
      @(negedge clk);
      chk("z_ready", {31'b0, ready0}, 32'd1);
      chk("z_stall", {31'b0, stall0}, 32'd0);
      e0 = addr_err(o_a);
      chk("z_err", {31'b0, err0}, {31'b0, e0});
      if (e0) exp_rd0 = 32'd0;
      else if (!o_we) exp_rd0 = mem0[int'(o_a >> 2)];
      chk("z_rd", rd0, exp_rd0);
      if (!e0 && o_we) mem0[int'(o_a >> 2)] = merge(mem0[int'(o_a >> 2)], o_wd, o_be);
      if (k < 47) begin
        // Favour read-after-write of the same word to hit the bypass.
        if (o_we && $urandom_range(0, 1) == 1) begin
          o_we = 1'b0;
          req0 = 1'b1; we0 = 1'b0; a0 = o_a;
        end else begin
          gen0(k + 1);
        end
      end else begin
        req0 = 1'b0;
      end
    end
    @(negedge clk);
    chk("z_ready_idle", {31'b0, ready0}, 32'd0);

    // Reset in the middle of a write's wait period.
    access2(1'b1, 32'h8, 32'hDEADBEEF, 4'hF);
    access2(1'b0, 32'h8, 32'h0, 4'h0);
    old14 = mem2[5];
    start2(1'b1, 32'h14, ~old14, 4'hF);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("abort_rd", rd, 32'd0);
    chk("abort_ready", {31'b0, ready}, 32'd0);
    chk("abort_err", {31'b0, err}, 32'd0);
    exp_rd2 = 32'd0;
    req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    access2(1'b0, 32'h14, 32'h0, 4'h0);
    chk("abort_nowrite", rd, old14);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_wait.md
DMEM_WAIT -- requirements
Module: dmem_wait

Interface
REQ-001 The module SHALL have parameter DATA_W, default 32, data word width in bits (multiple of 8).
REQ-002 The module SHALL have parameter ADDR_W, default 32, byte address width.
REQ-003 The module SHALL have parameter DEPTH, default 64, number of DATA_W words stored.
REQ-004 The module SHALL have parameter WAIT_CYCLES, default 2, range 0..15, extra cycles inserted before each response.
REQ-005 The module SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-006 The module SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-007 The module SHALL have port req, input, 1, access request, sampled only while idle or in the response cycle.
REQ-008 The module SHALL have port we, input, 1, 1 = write, 0 = read, captured with req.
REQ-009 The module SHALL have port a, input, ADDR_W, byte address, captured with req.
REQ-010 The module SHALL have port wd, input, DATA_W, write data, captured with req.
REQ-011 The module SHALL have port be, input, DATA_W/8, byte enables for writes, captured with req.
REQ-012 The module SHALL have port rd, output, DATA_W, registered read data.
REQ-013 The module SHALL have port ready, output, 1, one-cycle response pulse.
REQ-014 The module SHALL have port err, output, 1, error flag, valid only while ready=1.
REQ-015 The module SHALL have port stall, output, 1, combinational req & ~ready, used by the pipeline to freeze its memory stage.

Function
REQ-016 The FSM SHALL have states IDLE, WAIT, RESP.
REQ-017 In IDLE with req=1, the module SHALL capture we/a/wd/be, load the wait counter with WAIT_CYCLES, and go to WAIT, or to RESP if WAIT_CYCLES=0.
REQ-018 In WAIT, the counter SHALL decrement each cycle, with transition to RESP after the cycle in which it reaches 1.
REQ-019 ready SHALL be 1 exactly during RESP; latency from capture edge to ready = WAIT_CYCLES+1 cycles.
REQ-020 Word index SHALL be a[ADDR_W-1:2]; an access is in error if a[1:0]!=0 or the index is >= DEPTH.
REQ-021 An error access SHALL assert err with ready, write nothing, and load rd with 0.
REQ-022 A valid write SHALL update only the bytes whose be bit is 1, committed on the clock edge leaving RESP, and rd SHALL be unchanged.
REQ-023 A valid read SHALL load rd with the stored word on the edge entering RESP, and rd SHALL hold until the next read or error response.
REQ-024 In RESP with req=1, a new request SHALL be captured (back-to-back); otherwise the FSM SHALL return to IDLE.
REQ-025 Input changes while in WAIT SHALL be ignored; captured values SHALL govern the access.
REQ-026 A read of an address written by the immediately preceding back-to-back write SHALL return the new data.
REQ-027 be=0 on a write SHALL complete with ready and leave memory unchanged.

Reset
REQ-028 reset=0 SHALL immediately force state IDLE, counter 0, ready 0, err 0, rd 0, regardless of clk.
REQ-029 Reset during WAIT or RESP SHALL abort the access, with no memory write.
REQ-030 Reset SHALL NOT clear memory contents.
REQ-031 After reset deassertion, the first req SHALL be sampled on the next rising edge.

Verification
REQ-032 With WAIT_CYCLES=2, write a=0x8, wd=0xDEADBEEF, be=0xF -> ready high 3 cycles after capture; stall high during cycles 1-2; then a read of 0x8 returns 0xDEADBEEF.
REQ-033 Write a=0x8, wd=0x11223344, be=0b0101 over 0xDEADBEEF -> a read returns 0xDE22BE44.
REQ-034 Read a=0x6 (misaligned) and a=DEPTH*4 (out of range) -> ready with err=1, rd=0, memory unchanged.
REQ-035 Back-to-back write 0x10=0xCAFEF00D then read 0x10 with req held high -> responses 3 cycles apart, and the read returns 0xCAFEF00D.
REQ-036 Assert reset=0 mid-WAIT of a write to 0x14 -> outputs 0 asynchronously; a subsequent read of 0x14 returns its prior value.
REQ-037 With WAIT_CYCLES=0, a read -> ready on the cycle after capture, and continuous req yields one response every cycle.
